// File: rtl/decode_stage_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, funct codes,
// one-hot instruction-bus bit positions and the reset PC.
package decode_stage_pkg;

    localparam int BUS_W = 28;

    localparam int B_CAL_R = 27;
    localparam int B_CAL_I = 26;
    localparam int B_CAL_L = 25;
    localparam int B_CAL_S = 24;
    localparam int B_CAL_B = 23;
    localparam int B_CAL_M = 22;
    localparam int B_ADDU  = 21;
    localparam int B_SUBU  = 20;
    localparam int B_ORI   = 19;
    localparam int B_LW    = 18;
    localparam int B_SW    = 17;
    localparam int B_BEQ   = 16;
    localparam int B_LUI   = 15;
    localparam int B_J     = 14;
    localparam int B_JAL   = 13;
    localparam int B_JR    = 12;
    localparam int B_NOP   = 11;
    localparam int B_YNEW  = 10;
    localparam int B_ADD   = 9;
    localparam int B_SUB   = 8;
    localparam int B_AND   = 7;
    localparam int B_OR    = 6;
    localparam int B_XOR   = 5;
    localparam int B_NOR   = 4;
    localparam int B_ADDI  = 3;
    localparam int B_ADDIU = 2;
    localparam int B_ANDI  = 1;
    localparam int B_XORI  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_XORI  = 6'h0e;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 general register file: async clear, one write port, two
// combinational read ports; $0 always reads as zero.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// MIPS D stage: decode, register read with E/M/W forwarding, branch/jump
// resolution and the D/E pipeline register. GRF_DISPLAY_EN logs GRF writes.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shall,
    input  logic [31:0]       instrD,
    input  logic [31:0]       pc4D,
    input  logic [31:0]       nE_pc,
    input  logic [31:0]       nE_e32,
    input  logic [BUS_W-1:0]  nE_instrbus,
    input  logic              nE_grf_en,
    input  logic [4:0]        nE_a3,
    input  logic [31:0]       M_vin,
    input  logic              M_grf_en,
    input  logic [4:0]        M_a3,
    input  logic [31:0]       W_vin,
    input  logic [31:0]       W_pc,
    input  logic              W_grf_en,
    input  logic [4:0]        W_a3,
    input  logic [BUS_W-1:0]  W_instrbus,
    output logic              pccon,
    output logic [31:0]       wnpc,
    output logic [4:0]        E_a1,
    output logic [4:0]        E_a2,
    output logic [4:0]        E_a3,
    output logic [31:0]       E_v1,
    output logic [31:0]       E_v2,
    output logic [31:0]       E_e32,
    output logic [31:0]       E_pc,
    output logic              E_grf_en,
    output logic              E_dm_en,
    output logic [BUS_W-1:0]  E_instrbus
);

    logic [5:0]       opcode, funct;
    logic [4:0]       rs, rt, rd;
    logic [15:0]      imm16;
    logic [BUS_W-1:0] bus;
    logic [4:0]       a3;
    logic             grf_en, dm_en;
    logic [31:0]      e32, sext16;
    logic [31:0]      rf1, rf2, v1, v2;

    assign opcode = instrD[31:26];
    assign funct  = instrD[5:0];
    assign rs     = instrD[25:21];
    assign rt     = instrD[20:16];
    assign rd     = instrD[15:11];
    assign imm16  = instrD[15:0];
    assign sext16 = {{16{imm16[15]}}, imm16};

    always_comb begin
        bus = '0;
        case (opcode)
            OP_RTYPE: begin
                if (instrD != 32'd0) begin
                    bus[B_ADDU] = (funct == FN_ADDU);
                    bus[B_SUBU] = (funct == FN_SUBU);
                    bus[B_ADD]  = (funct == FN_ADD);
                    bus[B_SUB]  = (funct == FN_SUB);
                    bus[B_AND]  = (funct == FN_AND);
                    bus[B_OR]   = (funct == FN_OR);
                    bus[B_XOR]  = (funct == FN_XOR);
                    bus[B_NOR]  = (funct == FN_NOR);
                    bus[B_JR]   = (funct == FN_JR);
                end
                bus[B_NOP] = (instrD == 32'd0);
            end
            OP_ORI:   bus[B_ORI]   = 1'b1;
            OP_LW:    bus[B_LW]    = 1'b1;
            OP_SW:    bus[B_SW]    = 1'b1;
            OP_BEQ:   bus[B_BEQ]   = 1'b1;
            OP_LUI:   bus[B_LUI]   = 1'b1;
            OP_J:     bus[B_J]     = 1'b1;
            OP_JAL:   bus[B_JAL]   = 1'b1;
            OP_ADDI:  bus[B_ADDI]  = 1'b1;
            OP_ADDIU: bus[B_ADDIU] = 1'b1;
            OP_ANDI:  bus[B_ANDI]  = 1'b1;
            OP_XORI:  bus[B_XORI]  = 1'b1;
            default:  bus = '0;
        endcase
        bus[B_CAL_R] = bus[B_ADDU] | bus[B_SUBU] | bus[B_ADD] | bus[B_SUB] |
                       bus[B_AND]  | bus[B_OR]   | bus[B_XOR] | bus[B_NOR];
        bus[B_CAL_I] = bus[B_ORI] | bus[B_ADDI] | bus[B_ADDIU] | bus[B_ANDI] |
                       bus[B_XORI] | bus[B_LUI];
        bus[B_CAL_L] = bus[B_LW];
        bus[B_CAL_S] = bus[B_SW];
        bus[B_CAL_B] = bus[B_BEQ];
    end

    always_comb begin
        a3 = 5'd0;
        if (bus[B_CAL_R])                     a3 = rd;
        else if (bus[B_CAL_I] || bus[B_LW])   a3 = rt;
        else if (bus[B_JAL])                  a3 = 5'd31;
        grf_en = bus[B_CAL_R] | bus[B_CAL_I] | bus[B_LW] | bus[B_JAL];
        dm_en  = bus[B_SW];
    end

    always_comb begin
        if (bus[B_LUI])
            e32 = {imm16, 16'd0};
        else if (bus[B_CAL_L] | bus[B_CAL_S] | bus[B_ADDI] | bus[B_ADDIU])
            e32 = sext16;
        else
            e32 = {16'd0, imm16};
    end

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .we    (W_grf_en),
        .wa    (W_a3),
        .wd    (W_vin),
        .rd1   (rf1),
        .rd2   (rf2)
    );

    // A lui or jal still in E already knows its result, so it outranks M and W.
    function automatic logic [31:0] forward(input logic [4:0] a, input logic [31:0] rf);
        if (nE_instrbus[B_LUI] && nE_a3 != 5'd0 && nE_a3 == a)
            return nE_e32;
        else if (nE_instrbus[B_JAL] && a == 5'd31)
            return nE_pc + 32'd8;
        else if (M_grf_en && M_a3 == a && a != 5'd0)
            return M_vin;
        else if (W_grf_en && W_a3 == a && a != 5'd0)
            return W_vin;
        else
            return rf;
    endfunction

    assign v1 = forward(rs, rf1);
    assign v2 = forward(rt, rf2);

    always_comb begin
        pccon = (bus[B_BEQ] && v1 == v2) | bus[B_J] | bus[B_JAL] | bus[B_JR];
        wnpc  = pc4D;
        if (bus[B_BEQ] && v1 == v2)
            wnpc = pc4D + {sext16[29:0], 2'b00};
        else if (bus[B_JR])
            wnpc = v1;
        else if (bus[B_J] || bus[B_JAL])
            wnpc = {pc4D[31:28], instrD[25:0], 2'b00};
    end

    // A stall loads the same bubble as reset, but synchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_a1 <= '0; E_a2 <= '0; E_a3 <= '0;
            E_v1 <= '0; E_v2 <= '0; E_e32 <= '0;
            E_pc <= RESET_PC;
            E_grf_en <= 1'b0; E_dm_en <= 1'b0;
            E_instrbus <= '0;
        end else if (shall) begin
            E_a1 <= '0; E_a2 <= '0; E_a3 <= '0;
            E_v1 <= '0; E_v2 <= '0; E_e32 <= '0;
            E_pc <= RESET_PC;
            E_grf_en <= 1'b0; E_dm_en <= 1'b0;
            E_instrbus <= '0;
        end else begin
            E_a1 <= rs; E_a2 <= rt; E_a3 <= a3;
            E_v1 <= v1; E_v2 <= v2; E_e32 <= e32;
            E_pc <= pc4D - 32'd4;
            E_grf_en <= grf_en; E_dm_en <= dm_en;
            E_instrbus <= bus;
        end
    end

`ifdef GRF_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!reset && W_grf_en && W_a3 != 5'd0)
            $display("@%h: $%0d <= %h", W_pc, W_a3, W_vin);
    end

    logic unused_inputs;
    assign unused_inputs = ^{W_instrbus, nE_grf_en};
`else
    logic unused_inputs;
    assign unused_inputs = ^{W_instrbus, nE_grf_en, W_pc};
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed
// expected values for decode, extension, forwarding, branches and stalls.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        shall;
    logic [31:0] instrD, pc4D;
    logic [31:0] nE_pc, nE_e32;
    logic [27:0] nE_instrbus;
    logic        nE_grf_en;
    logic [4:0]  nE_a3;
    logic [31:0] M_vin;
    logic        M_grf_en;
    logic [4:0]  M_a3;
    logic [31:0] W_vin, W_pc;
    logic        W_grf_en;
    logic [4:0]  W_a3;
    logic [27:0] W_instrbus;
    logic        pccon;
    logic [31:0] wnpc;
    logic [4:0]  E_a1, E_a2, E_a3;
    logic [31:0] E_v1, E_v2, E_e32, E_pc;
    logic        E_grf_en, E_dm_en;
    logic [27:0] E_instrbus;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .shall(shall),
        .instrD(instrD), .pc4D(pc4D),
        .nE_pc(nE_pc), .nE_e32(nE_e32), .nE_instrbus(nE_instrbus),
        .nE_grf_en(nE_grf_en), .nE_a3(nE_a3),
        .M_vin(M_vin), .M_grf_en(M_grf_en), .M_a3(M_a3),
        .W_vin(W_vin), .W_pc(W_pc), .W_grf_en(W_grf_en), .W_a3(W_a3),
        .W_instrbus(W_instrbus),
        .pccon(pccon), .wnpc(wnpc),
        .E_a1(E_a1), .E_a2(E_a2), .E_a3(E_a3),
        .E_v1(E_v1), .E_v2(E_v2), .E_e32(E_e32), .E_pc(E_pc),
        .E_grf_en(E_grf_en), .E_dm_en(E_dm_en), .E_instrbus(E_instrbus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc4);
        instrD = instr;
        pc4D   = pc4;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearFwd();
        nE_pc = '0; nE_e32 = '0; nE_instrbus = '0; nE_grf_en = 1'b0; nE_a3 = '0;
        M_vin = '0; M_grf_en = 1'b0; M_a3 = '0;
        W_vin = '0; W_pc = '0; W_grf_en = 1'b0; W_a3 = '0; W_instrbus = '0;
    endtask

    initial begin
        reset = 1'b1; shall = 1'b0;
        instrD = '0; pc4D = '0;
        clearFwd();
        #12;
        checkOutput("rst_E_pc", E_pc, 32'h0000_3000);
        checkOutput("rst_E_bus", {4'd0, E_instrbus}, 32'd0);
        checkOutput("rst_E_v1", E_v1, 32'd0);
        checkOutput("rst_E_grf_en", {31'd0, E_grf_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // write $5 while reading it (forwarded), then read it from the GRF
        W_grf_en = 1'b1; W_a3 = 5'd5; W_vin = 32'h1234; W_pc = 32'h3000;
        applyStimulus(32'h00A0_3021, 32'h0000_3004);
        tick();
        checkOutput("wr5_fwd_v1", E_v1, 32'h1234);
        checkOutput("wr5_E_pc", E_pc, 32'h3000);
        W_grf_en = 1'b0; W_vin = 32'h0; W_a3 = 5'd0;
        tick();
        checkOutput("rd5_v1", E_v1, 32'h1234);
        checkOutput("addu_a3", {27'd0, E_a3}, 32'd6);
        checkOutput("addu_bus", {4'd0, E_instrbus}, 32'h0820_0000);

        applyStimulus(32'h3401_ffff, 32'h0000_3008);
        tick();
        checkOutput("ori_e32", E_e32, 32'h0000_ffff);
        checkOutput("ori_a3", {27'd0, E_a3}, 32'd1);
        checkOutput("ori_grf_en", {31'd0, E_grf_en}, 32'd1);
        checkOutput("ori_bus", {4'd0, E_instrbus}, 32'h0408_0000);

        applyStimulus(32'h8c62_fffc, 32'h0000_300c);
        tick();
        checkOutput("lw_e32", E_e32, 32'hffff_fffc);
        checkOutput("lw_a3", {27'd0, E_a3}, 32'd2);

        applyStimulus(32'h3C04_8000, 32'h0000_3010);
        tick();
        checkOutput("lui_e32", E_e32, 32'h8000_0000);
        checkOutput("lui_a3", {27'd0, E_a3}, 32'd4);
        checkOutput("lui_bus", {4'd0, E_instrbus}, 32'h0400_8000);

        // beq $1,$2,+3 with $1 from M and $2 from W
        M_grf_en = 1'b1; M_a3 = 5'd1; M_vin = 32'd7;
        W_grf_en = 1'b1; W_a3 = 5'd2; W_vin = 32'd7;
        applyStimulus(32'h1022_0003, 32'h0000_3044);
        checkOutput("beq_eq_pccon", {31'd0, pccon}, 32'd1);
        checkOutput("beq_eq_wnpc", wnpc, 32'h0000_3050);
        W_vin = 32'd8;
        #1;
        checkOutput("beq_ne_pccon", {31'd0, pccon}, 32'd0);
        checkOutput("beq_ne_wnpc", wnpc, 32'h0000_3044);
        clearFwd();

        applyStimulus(32'h1000_fffe, 32'h0000_3100);
        checkOutput("beq_back_pccon", {31'd0, pccon}, 32'd1);
        checkOutput("beq_back_wnpc", wnpc, 32'h0000_30f8);

        // jal in E, jr $31 in D
        nE_instrbus = 28'h000_2000; nE_pc = 32'h3010; nE_a3 = 5'd31; nE_grf_en = 1'b1;
        applyStimulus(32'h03E0_0008, 32'h0000_3018);
        checkOutput("jr_wnpc", wnpc, 32'h0000_3018);
        checkOutput("jr_pccon", {31'd0, pccon}, 32'd1);
        tick();
        checkOutput("jr_E_v1", E_v1, 32'h0000_3018);
        checkOutput("jr_bus", {4'd0, E_instrbus}, 32'h0000_1000);
        clearFwd();

        applyStimulus(32'h0800_0400, 32'h4000_3000);
        checkOutput("j_wnpc", wnpc, 32'h4000_1000);
        checkOutput("j_pccon", {31'd0, pccon}, 32'd1);

        // E-stage lui outranks M for $3
        nE_instrbus = 28'h400_8000; nE_a3 = 5'd3; nE_e32 = 32'habcd_0000;
        M_grf_en = 1'b1; M_a3 = 5'd3; M_vin = 32'd1;
        applyStimulus(32'h0060_3821, 32'h0000_3200);
        tick();
        checkOutput("fwd_e_lui", E_v1, 32'habcd_0000);
        nE_instrbus = '0; nE_a3 = '0; nE_e32 = '0;
        tick();
        checkOutput("fwd_m", E_v1, 32'd1);
        clearFwd();

        // stall bubble while W tries to write $0
        shall = 1'b1;
        W_grf_en = 1'b1; W_a3 = 5'd0; W_vin = 32'hdead_beef;
        applyStimulus(32'h3401_ffff, 32'h0000_3300);
        tick();
        checkOutput("stall_bus", {4'd0, E_instrbus}, 32'd0);
        checkOutput("stall_grf_en", {31'd0, E_grf_en}, 32'd0);
        checkOutput("stall_E_pc", E_pc, 32'h0000_3000);
        checkOutput("stall_e32", E_e32, 32'd0);
        shall = 1'b0;
        clearFwd();
        applyStimulus(32'h0000_4021, 32'h0000_3304);
        tick();
        checkOutput("r0_v1", E_v1, 32'd0);
        checkOutput("r0_a3", {27'd0, E_a3}, 32'd8);

        applyStimulus(32'hFC00_0000, 32'h0000_3308);
        tick();
        checkOutput("unk_bus", {4'd0, E_instrbus}, 32'd0);
        checkOutput("unk_grf_en", {31'd0, E_grf_en}, 32'd0);

        applyStimulus(32'hAC62_0008, 32'h0000_330c);
        tick();
        checkOutput("sw_dm_en", {31'd0, E_dm_en}, 32'd1);
        checkOutput("sw_grf_en", {31'd0, E_grf_en}, 32'd0);
        checkOutput("sw_a3", {27'd0, E_a3}, 32'd0);
        checkOutput("sw_e32", E_e32, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode (D) stage of the five-stage MIPS pipeline. Decodes the D-stage instruction into a one-hot instruction bus, register addresses and enables, and reads the 32×32 register file. It forwards operands from E, M and W, resolves branches and jumps, computes the next PC, and updates the D/E pipeline register.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `shall` in 1: stall. Inserts a bubble into the D/E register.
- `instrD`, `pc4D` in 32 each: D-stage instruction and PC+4.
- `nE_pc`, `nE_e32` in 32 each; `nE_instrbus` in 28; `nE_grf_en` in 1; `nE_a3` in 5: current E-stage state, used for forwarding.
- `M_vin` in 32; `M_grf_en` in 1; `M_a3` in 5: M-stage forwarding source.
- `W_vin`, `W_pc` in 32 each; `W_grf_en` in 1; `W_a3` in 5; `W_instrbus` in 28: register-file write port (`W_instrbus` unused).
- `pccon` out 1: redirect taken.
- `wnpc` out 32: next PC.
- `E_a1`, `E_a2`, `E_a3` out 5 each; `E_v1`, `E_v2`, `E_e32`, `E_pc` out 32 each; `E_grf_en`, `E_dm_en` out 1 each; `E_instrbus` out 28: D/E register.

## Operation
- **Instruction bus:** 28 bits. Bit 27 down to bit 0 is: cal_r, cal_i, cal_l, cal_s, cal_b, cal_m, addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop, ynew, add, sub, and, or, xor, nor, addi, addiu, andi, xori.
- **Opcode decode:**
  - Opcode 0 plus funct: addu 0x21, subu 0x23, add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, jr 0x08.
  - Other opcodes: ori 0x0d, lw 0x23, sw 0x2b, beq 0x04, lui 0x0f, j 0x02, jal 0x03, addi 0x08, addiu 0x09, andi 0x0c, xori 0x0e.
  - nop = instr==0. An all-zero instruction is not addu-decoded.
- **Class flags:**
  - cal_r = any R-type ALU op.
  - cal_i = ori/addi/addiu/andi/xori/lui.
  - cal_l = lw; cal_s = sw; cal_b = beq.
  - cal_m and ynew are always 0 (reserved).
  - An unknown opcode decodes to all-zero: no writes.
- **Addresses:**
  - a1 = rs, a2 = rt.
  - a3 = rd for cal_r; rt for cal_i/lw; 31 for jal; else 0.
  - grf_en = cal_r|cal_i|lw|jal. dm_en = sw.
- **Extender:**
  - lui → {imm16, 16'b0}.
  - Else signcon=(cal_l|cal_s|addi|addiu) → sign-extend imm16.
  - Otherwise zero-extend imm16.
- **Forwarding (v1 for a1; v2 identical for a2), priority order:**
  1. E is lui, nE_a3≠0 and nE_a3==a → nE_e32.
  2. E is jal and a==31 → nE_pc+8.
  3. M_grf_en, M_a3==a≠0 → M_vin.
  4. W_grf_en, W_a3==a≠0 → W_vin.
  5. Otherwise the register-file read.
- **Register file:**
  - Read: combinational; $0 reads 0.
  - Write: on the rising edge when W_grf_en and W_a3≠0, writes W_vin.
  - Reset: clears all 32 registers.
- **Branch/NPC:**
  - zero1 = (v1==v2).
  - pccon = (beq&zero1)|j|jal|jr.
  - wnpc: beq taken → pc4D + (sext(imm16)<<2); jr → v1; j/jal → {pc4D[31:28], imm26, 2'b00}; else pc4D.

## Timing
- Decode, forwarding and NPC are combinational; wnpc/pccon are valid in the same cycle.
- D/E register updates at posedge clk: E_pc←pc4D−4, E_v1/E_v2←forwarded values, all other E_* fields←decoded values.
- reset (asynchronous):
  - All E_* outputs go to 0, except E_pc = 0x00003000.
  - All registers clear.
- shall=1 at an edge loads the same reset values (synchronous bubble). The register file still writes normally.
- A simultaneous W write and D read of the same register returns W_vin, through the forwarding mux.

## Configuration
- `GRF_DISPLAY_EN` defined: every register write prints `@<W_pc hex>: $<W_a3 dec> <= <W_vin hex>`.
- Undefined: no display; behaviour otherwise identical.

## Structure
- Shared package holds:
  - Opcode and funct constants.
  - Instruction-bus bit indices and width (28).
  - Reset PC 0x00003000.
- Natural sub-module: `regfile` (32×32, async reset, two combinational read ports). Decoder, extender and NPC stay inline.

## Test plan
- Reset, then release → E_pc=0x3000 and other E_* = 0. After writing $5=0x1234 via W, reading rs=5 gives v1=0x1234.
- instrD=ori $1,$0,0xffff (0x3401ffff) → E_e32=0x0000ffff, E_a3=1, E_grf_en=1, cal_i and ori bits set.
- instrD=lw $2,-4($3) (0x8c62fffc) → E_e32=0xfffffffc and E_a3=2. instrD=lui $4,0x8000 → E_e32=0x80000000.
- beq $1,$2,+3 with M forwarding $1=7 and W forwarding $2=7 → pccon=1, wnpc=pc4D+12. With values 7 vs 8 → pccon=0, wnpc=pc4D.
- E holds jal at nE_pc=0x3010 and D holds jr $31 → v1=0x3018, wnpc=0x3018, pccon=1.
- shall=1 with a valid instrD → the next cycle shows E_instrbus=0, E_grf_en=0, E_pc=0x3000. A W write of $0 leaves $0=0.
